instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

- Front-end fetch stage of the ARM-subset core.
- Owns the program counter and drives a word address into the combinational instruction memory, which returns the instruction word in the same cycle.
- Forwards non-branch instructions to decode through a one-entry valid/ready output register.
- Resolves B-class branches (bits 27:25 = 101) locally against the NZCV flags supplied by the back end.

## Interface

Parameters:
- RESET_PC, 32'd0, word address loaded into the PC on reset

Ports:
- clk  input  1  single clock for the block; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_addr  output  32  word address to instruction memory; equals PC
- imem_data  input  32  instruction word at imem_addr, same cycle
- flags_nzcv  input  4  architectural flags {N,Z,C,V}
- flags_valid  input  1  flags reflect every instruction older than the fetched word
- instr_out  output  32  instruction presented to decode
- pc_out  output  32  word address of instr_out
- instr_valid  output  1  instr_out/pc_out valid
- instr_ready  input  1  decode accepts instr_out this cycle
- redirect  output  1  one-cycle pulse: taken branch loaded a new PC
- halted  output  1  fetch stopped on self-branch (see Configuration)

## Operation

- Reset values:
  - PC = RESET_PC, instr_out = 0, pc_out = 0
  - instr_valid = 0, redirect = 0, halted = 0
  - state = RUN
- States: RUN, WAIT_FLAGS, HALT.
- Advance condition: adv = (!instr_valid | instr_ready). When adv = 0, PC, state and the output register all hold.
- RUN with adv, non-branch word:
  - Load instr_out = imem_data, pc_out = PC, instr_valid = 1.
  - PC <= PC+1.
  - The condition field is not evaluated; decode/execute handle it.
- RUN with adv, branch word (imem_data[27:25] = 3'b101):
  - The branch is consumed and never forwarded; set instr_valid <= 0 (bubble).
  - If cond = AL (1110), or flags_valid = 1, resolve this cycle. Otherwise go to WAIT_FLAGS with PC held.
  - Taken: PC <= PC + 1 + sext32(imem_data[23:0]), computed modulo 2^32; redirect = 1.
  - Not taken: PC <= PC+1.
  - L bit (24) is ignored. BL behaves as B; no link write.
- WAIT_FLAGS:
  - imem_addr stays at the branch's PC; instr_valid = 0.
  - On the first cycle with flags_valid = 1, resolve as above and return to RUN.
- Condition evaluation uses standard ARM semantics for EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE and AL. 1111 is never taken.
- Both redirect and not-taken resolution take effect the cycle after resolution: the new imem_addr is visible then.

## Timing

- Fetch-to-decode latency: 1 cycle. The word at PC appears on instr_out the cycle after it is sampled.
- Straight-line throughput: 1 instruction/cycle while instr_ready = 1.
- Taken or not-taken branch cost:
  - Unconditional or flags_valid branch: exactly 1 bubble cycle.
  - Waiting branch: plus one cycle per cycle flags_valid is low.
- redirect is high for exactly one cycle per taken branch, including in the same cycle the HALT transition is made.
- Backpressure:
  - With instr_valid = 1 and instr_ready = 0, instr_out, pc_out, PC and imem_addr are frozen.
  - A pending branch at PC is not resolved until adv = 1.
- Reset mid-operation: async assertion forces all reset values immediately, from any state including WAIT_FLAGS and HALT.
- PC wraps 32'hFFFFFFFF -> 0 on increment; no error.

## Configuration

- FETCH_HALT_DETECT_EN defined:
  - A taken branch whose target equals its own PC (offset 24'hFFFFFF) enters HALT.
  - In HALT: halted = 1, instr_valid = 0, PC frozen; exit only by reset.
- Undefined:
  - No HALT state; halted is tied 0.
  - The self-branch redirects to the same PC each resolution: redirect pulses every cycle and instr_valid stays 0.

## Test plan

- Straight-line:
  - Stimulus: non-branch words at 0..3, instr_ready = 1.
  - Response: instr_valid = 1 from cycle 1; pc_out = 0, 1, 2, 3 on consecutive cycles; no bubbles.
- Backpressure:
  - Stimulus: instr_ready = 0 for 3 cycles while pc_out = 5.
  - Response: instr_out, pc_out = 5 and imem_addr = 6 held; on release, pc_out = 6 the next cycle.
- Taken conditional branch:
  - Stimulus: 32'hBAFFFFF7 (BLT #-9) at address 36; flags_valid = 0 for 2 cycles, then NZCV = 4'b1000.
  - Response: WAIT_FLAGS for 2 cycles, then redirect = 1 and imem_addr = 28 the following cycle; the branch never appears on instr_out.
- Not-taken branch:
  - Stimulus: same word with NZCV = 4'b0000 and flags_valid = 1.
  - Response: one bubble, then imem_addr = 37; redirect stays 0.
- Self-branch:
  - Stimulus: 32'hEAFFFFFF at address 46.
  - Response with macro: halted = 1 next cycle, imem_addr fixed at 46, instr_valid = 0 indefinitely.
  - Response without macro: redirect pulses every cycle, imem_addr = 46.
- Reset mid-wait:
  - Stimulus: rst asserted asynchronously during WAIT_FLAGS.
  - Response: same-cycle instr_valid = 0, redirect = 0, imem_addr = RESET_PC; RUN resumes after deassertion.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory port, back-end flags and the decode handshake.
interface instr_fetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [3:0]  flags_nzcv;
  logic        flags_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic        halted;

  modport master (
    output imem_addr,
    input  imem_data,
    input  flags_nzcv,
    input  flags_valid,
    output instr_out,
    output pc_out,
    output instr_valid,
    input  instr_ready,
    output redirect,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output flags_nzcv,
    output flags_valid,
    input  instr_out,
    input  pc_out,
    input  instr_valid,
    output instr_ready,
    input  redirect,
    input  halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, forwards non-branch words to decode, resolves B-class branches locally.
// Optional FETCH_HALT_DETECT_EN: a taken self-branch parks fetch in a HALT state until reset.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic clk,
  input logic rst,
  instr_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {StRun, StWaitFlags, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        redirect_q, redirect_d;

  logic        adv;
  logic        is_branch;
  logic        resolve;
  logic        cond_pass;
  logic [3:0]  cond;
  logic [31:0] pc_inc;
  logic [31:0] target;

  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_check = z;
      4'b0001: cond_check = !z;
      4'b0010: cond_check = cf;
      4'b0011: cond_check = !cf;
      4'b0100: cond_check = n;
      4'b0101: cond_check = !n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = !v;
      4'b1000: cond_check = cf && !z;
      4'b1001: cond_check = !cf || z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = !z && (n == v);
      4'b1101: cond_check = z || (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  always_comb begin
    adv       = !valid_q || bus.instr_ready;
    is_branch = (bus.imem_data[27:25] == 3'b101);
    cond      = bus.imem_data[31:28];
    cond_pass = cond_check(cond, bus.flags_nzcv);
    pc_inc    = pc_q + 32'd1;
    target    = pc_inc + {{8{bus.imem_data[23]}}, bus.imem_data[23:0]};
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_out_d   = pc_out_q;
    valid_d    = valid_q;
    redirect_d = 1'b0;
    resolve    = 1'b0;

    unique case (state_q)
      StRun: begin
        if (adv) begin
          if (!is_branch) begin
            instr_d  = bus.imem_data;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_inc;
          end else begin
            // Branches are consumed here; decode only sees a bubble.
            valid_d = 1'b0;
            if ((cond == 4'b1110) || bus.flags_valid) begin
              resolve = 1'b1;
            end else begin
              state_d = StWaitFlags;
            end
          end
        end
      end
      StWaitFlags: begin
        valid_d = 1'b0;
        resolve = bus.flags_valid;
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: state_d = StRun;
    endcase

    if (resolve) begin
      state_d = StRun;
      if (cond_pass) begin
        pc_d       = target;
        redirect_d = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
        if (target == pc_q) begin
          state_d = StHalt;
        end
`endif
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      pc_out_q   <= 32'd0;
      valid_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_out_q   <= pc_out_d;
      valid_q    <= valid_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.instr_valid = valid_q;
  assign bus.redirect    = redirect_q;
`ifdef FETCH_HALT_DETECT_EN
  assign bus.halted = (state_q == StHalt);
`else
  assign bus.halted = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus a random run
// checked every cycle against a behavioural fetch model.
module tb_instr_fetch_unit;

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'd0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [64];
  assign bus.imem_data = mem[bus.imem_addr[5:0]];

  int vectors = 0;
  int miscompares = 0;

  // Model state: what the outputs must show this cycle.
  logic [31:0] m_pc, m_out, m_pc_out;
  bit          m_valid, m_redirect, m_halted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit arm_cond(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_out = 32'd0; m_pc_out = 32'd0;
    m_valid = 0; m_redirect = 0; m_halted = 0;
  endtask

  // One clock of fetch behaviour. A waiting branch is simply "branch at PC, no flags": PC holds.
  task automatic model_next();
    logic [31:0] w, tgt;
    m_redirect = 0;
    if (m_halted) return;
    if (m_valid && !bus.instr_ready) return;
    w = mem[m_pc[5:0]];
    if (w[27:25] != 3'b101) begin
      m_out = w; m_pc_out = m_pc; m_valid = 1; m_pc = m_pc + 1;
    end else begin
      m_valid = 0;
      if (w[31:28] == 4'd14 || bus.flags_valid) begin
        if (arm_cond(w[31:28], bus.flags_nzcv)) begin
          tgt = m_pc + 1 + {{8{w[23]}}, w[23:0]};
          if (HaltEn && tgt == m_pc) m_halted = 1;
          m_redirect = 1;
          m_pc = tgt;
        end else begin
          m_pc = m_pc + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("imem_addr", bus.imem_addr, m_pc);
    check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    check("instr_out", bus.instr_out, m_out);
    check("pc_out", bus.pc_out, m_pc_out);
    check("redirect", 32'(bus.redirect), 32'(m_redirect));
    check("halted", 32'(bus.halted), 32'(m_halted));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    compare_all();
    rst = 1'b0;
  endtask

  task automatic step_until(input logic [31:0] addr);
    int n = 0;
    while (bus.imem_addr !== addr && n < 64) begin
      step();
      n++;
    end
    check("reach_addr", bus.imem_addr, addr);
  endtask

  task automatic fill_straight();
    for (int i = 0; i < 64; i++) mem[i] = 32'hE280_0000 | 32'(i);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int off;
    logic [3:0] c;
    if ($urandom_range(9) < 3) begin
      off = int'($urandom_range(20)) - 10;
      if (off == -1) off = 2;
      c = 4'($urandom_range(15));
      w = {c, 3'b101, 1'($urandom_range(1)), 24'(off)};
    end else begin
      w = $urandom;
      if (w[27:25] == 3'b101) w[25] = 1'b0;
    end
    return w;
  endfunction

  initial begin
    bus.instr_ready = 1'b1;
    bus.flags_valid = 1'b1;
    bus.flags_nzcv  = 4'b0000;
    fill_straight();
    mem[8]  = 32'hEA00_001B;   // B to 36
    mem[36] = 32'hBAFF_FFF7;   // BLT #-9 -> 28
    mem[46] = 32'hEAFF_FFFF;   // self-branch
    @(negedge clk);
    do_reset();
    check("reset_addr", bus.imem_addr, 32'd0);
    check("reset_valid", 32'(bus.instr_valid), 32'd0);
    check("reset_instr", bus.instr_out, 32'd0);

    // Straight-line, then backpressure at pc_out = 5.
    step();
    check("sl_valid0", 32'(bus.instr_valid), 32'd1);
    check("sl_instr0", bus.instr_out, 32'hE280_0000);
    for (int k = 2; k <= 6; k++) begin
      step();
      check("sl_pc_out", bus.pc_out, 32'(k - 1));
    end
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("bp_pc_out", bus.pc_out, 32'd5);
      check("bp_addr", bus.imem_addr, 32'd6);
      check("bp_instr", bus.instr_out, 32'hE280_0005);
    end
    bus.instr_ready = 1'b1;
    step();
    check("bp_release", bus.pc_out, 32'd6);
    step();
    // AL branch at 8 resolves without flags.
    bus.flags_valid = 1'b0;
    step();
    check("al_redirect", 32'(bus.redirect), 32'd1);
    check("al_addr", bus.imem_addr, 32'd36);
    check("al_bubble", 32'(bus.instr_valid), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step();
      check("wait_addr", bus.imem_addr, 32'd36);
      check("wait_redirect", 32'(bus.redirect), 32'd0);
    end
    bus.flags_valid = 1'b1;
    bus.flags_nzcv  = 4'b1000;
    step();
    check("blt_redirect", 32'(bus.redirect), 32'd1);
    check("blt_addr", bus.imem_addr, 32'd28);
    check("blt_pc_out", bus.pc_out, 32'd7);

    // Not-taken pass over the same branch.
    bus.flags_nzcv = 4'b0000;
    step_until(32'd36);
    step();
    check("nt_addr", bus.imem_addr, 32'd37);
    check("nt_redirect", 32'(bus.redirect), 32'd0);
    check("nt_bubble", 32'(bus.instr_valid), 32'd0);

    // Self-branch at 46.
    step_until(32'd46);
    step();
    check("self_redirect", 32'(bus.redirect), 32'd1);
    check("self_halted", 32'(bus.halted), 32'(HaltEn));
    for (int k = 0; k < 3; k++) begin
      step();
      check("self_addr", bus.imem_addr, 32'd46);
      check("self_valid", 32'(bus.instr_valid), 32'd0);
      check("self_pulse", 32'(bus.redirect), 32'(!HaltEn));
    end

    // Reset asserted mid-wait.
    do_reset();
    mem[2] = 32'h0A00_0005;   // BEQ
    bus.flags_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("mw_addr", bus.imem_addr, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("mw_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("mw_rst_redirect", 32'(bus.redirect), 32'd0);
    check("mw_rst_addr", bus.imem_addr, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    bus.flags_valid = 1'b1;
    step();
    check("mw_resume_valid", 32'(bus.instr_valid), 32'd1);
    check("mw_resume_pc", bus.pc_out, 32'd0);

    // Random programs, inputs and backpressure.
    for (int seg = 0; seg < 6; seg++) begin
      for (int i = 0; i < 64; i++) mem[i] = rand_word();
      do_reset();
      for (int c = 0; c < 400; c++) begin
        bus.instr_ready = ($urandom_range(3) != 0);
        bus.flags_valid = ($urandom_range(1) != 0);
        bus.flags_nzcv  = 4'($urandom_range(15));
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
